tiled_matmul_sequencer: RTL and testbench
=========================================

// Module: tiled_matmul_sequencer
// PURPOSE
//  Sequences a large C = A x B as TILE x TILE blocks over a shared tile multiplier.
//  Walks output tiles (i,j) and reduction index k, issuing A(i,k)/B(k,j) base addresses.
//  Accumulates partial tiles locally and writes each finished C tile back one row per beat.
//  Sits between the top-level op controller and the tile multiplier / memory write port.
// PARAMETERS
//  TILE    8   tile edge, in elements; power of two >= 2
//  ADDR_W  16  element-address width
//  DIM_W   16  matrix-dimension width
//  DATA_W  32  element width, two's complement
// PORTS
//  clock         in   1              sole clock
//  reset_n       in   1              asynchronous, active-low reset
//  start         in   1              1-cycle op request; sampled only in IDLE
//  dim_m         in   DIM_W          rows of A and C
//  dim_k         in   DIM_W          cols of A = rows of B
//  dim_n         in   DIM_W          cols of B and C
//  base_a        in   ADDR_W         A base address, row-major, 1 element per address
//  base_b        in   ADDR_W         B base address, row-major
//  base_c        in   ADDR_W         C base address, row-major
//  busy          out  1              high from accepted start until done
//  done          out  1              1-cycle pulse when the final C row is accepted
//  err_dim       out  1              1-cycle pulse; start rejected for bad dims
//  mult_start    out  1              1-cycle tile-multiply request
//  mult_base_a   out  ADDR_W         A tile base = base_a + i*TILE*dim_k + k*TILE
//  mult_base_b   out  ADDR_W         B tile base = base_b + k*TILE*dim_n + j*TILE
//  mult_stride_a out  DIM_W          row stride of A (= dim_k)
//  mult_stride_b out  DIM_W          row stride of B (= dim_n)
//  mult_done     in   1              tile product valid on mult_out this cycle
//  mult_out      in   TILE*TILE*DATA_W  product tile, element [r][c] at index r*TILE+c
//  wr_valid      out  1              C row beat valid
//  wr_ready      in   1              memory accepts beat when wr_valid & wr_ready
//  wr_addr       out  ADDR_W         base_c + (i*TILE+r)*dim_n + j*TILE
//  wr_data       out  TILE*DATA_W    accumulator row r, element c at index c
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, indices and accumulator cleared; mid-op reset aborts, no done.
//  Start (IDLE only): latch dims and bases; 0 or non-multiple of TILE in any dim -> err_dim next cycle, stay IDLE.
//  Otherwise busy=1; i=j=k=0 -> ISSUE. start while busy is ignored.
//  FSM: IDLE -> ISSUE -> WAIT_MULT -> ACCUM -> (ISSUE | WRITE) -> ... -> DONE -> IDLE.
//  ISSUE: mult_start=1 one cycle; mult_base_* and strides stable from ISSUE until mult_done.
//  WAIT_MULT: hold until mult_done; mult_done in any other state is ignored.
//  ACCUM (1 cycle): k==0 loads acc=mult_out, else acc+=mult_out elementwise, mod 2^DATA_W.
//  ACCUM exit: k<dim_k/TILE-1 -> k++, ISSUE; else r=0, WRITE.
//  WRITE: wr_valid=1; addr/data stable while stalled; on accept r++.
//  Last row (r==TILE-1) accepted: k=0; j++; j wraps at dim_n/TILE with i++.
//  After last row of the final tile (i,j both last) -> DONE, else -> ISSUE.
//  DONE: done=1, busy=0 that cycle, -> IDLE. Loop order i outer, j middle, k inner.
//  Address arithmetic truncates to ADDR_W (wraps); no range checking.
//  Min latency per k step: 3 cycles + multiplier latency; per C tile: +TILE beats.
// CONFIGURATION
//  MATMUL_SATURATE_EN defined: ACCUM add is signed-saturating to DATA_W
//   (clamp to 2^(DATA_W-1)-1 / -2^(DATA_W-1)); k==0 load is unchanged.
//  Undefined: wrap-around add mod 2^DATA_W, no saturation logic.
// TESTING
//  8x8x8, A=I, B[r][c]=r*8+c -> one mult_start, 8 beats, wr_data==B rows, done.
//  16x16x16 bases 0/256/512 -> issue order (i,j,k) = 000,001,010,011,100,...; 8 tile mults, 32 beats.
//  m=16,k=24,n=8, all-ones A,B -> 3 k steps per tile, every C element = 24, 2 tiles.
//  dim_k=12 -> err_dim pulse, busy stays 0, no mult_start or wr_valid.
//  wr_ready low 5 cycles at row 3 -> wr_addr/wr_data held, no beat lost or duplicated.
//  With MATMUL_SATURATE_EN, k=16, products 0x7FFFFFF0 each step -> result 0x7FFFFFFF.
//  reset_n low during WAIT_MULT -> all outputs 0; fresh start then completes correctly.

Source files
------------

// File: rtl/tiled_matmul_sequencer.sv
// Walks output tiles (i,j) and reduction steps k over a shared tile multiplier, accumulates
// partial tiles locally and streams each finished C tile out one row per beat.
// Optional build macro MATMUL_SATURATE_EN: signed-saturating accumulate instead of wrap-around.
module tiled_matmul_sequencer #(
    parameter int TILE   = 8,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [DIM_W-1:0]              dim_m,
    input  logic [DIM_W-1:0]              dim_k,
    input  logic [DIM_W-1:0]              dim_n,
    input  logic [ADDR_W-1:0]             base_a,
    input  logic [ADDR_W-1:0]             base_b,
    input  logic [ADDR_W-1:0]             base_c,
    output logic                          busy,
    output logic                          done,
    output logic                          err_dim,
    output logic                          mult_start,
    output logic [ADDR_W-1:0]             mult_base_a,
    output logic [ADDR_W-1:0]             mult_base_b,
    output logic [DIM_W-1:0]              mult_stride_a,
    output logic [DIM_W-1:0]              mult_stride_b,
    input  logic                          mult_done,
    input  logic [TILE*TILE*DATA_W-1:0]   mult_out,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [TILE*DATA_W-1:0]        wr_data
);

    localparam int LOG2_T = $clog2(TILE);
    localparam int WIDE_W = ADDR_W + DIM_W;
    localparam int ROW_W  = TILE * DATA_W;
    localparam logic [DIM_W-1:0]  ONE_D  = 1;
    localparam logic [LOG2_T-1:0] ONE_R  = 1;
    localparam logic [LOG2_T-1:0] R_LAST = TILE - 1;
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_MULT,
        S_ACCUM,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic [DIM_W-1:0]    m_tiles_reg, k_tiles_reg, n_tiles_reg;
    logic [DIM_W-1:0]    dim_k_reg, dim_n_reg;
    logic [ADDR_W-1:0]   base_a_reg, base_b_reg, base_c_reg;
    logic [DIM_W-1:0]    i_reg, j_reg, k_reg;
    logic [LOG2_T-1:0]   r_reg;

    function automatic logic [WIDE_W-1:0] widen_d(input logic [DIM_W-1:0] x);
        return {{(WIDE_W-DIM_W){1'b0}}, x};
    endfunction

    function automatic logic [WIDE_W-1:0] widen_a(input logic [ADDR_W-1:0] x);
        return {{(WIDE_W-ADDR_W){1'b0}}, x};
    endfunction

    function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] sum;
        sum = a + b;
`ifdef MATMUL_SATURATE_EN
        // Overflow only when both operands share a sign the result does not.
        if ((a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]))
            sum = a[DATA_W-1] ? SAT_MIN : SAT_MAX;
`endif
        return sum;
    endfunction

    logic dims_bad;
    assign dims_bad = (dim_m == '0) || (dim_m[LOG2_T-1:0] != '0) ||
                      (dim_k == '0) || (dim_k[LOG2_T-1:0] != '0) ||
                      (dim_n == '0) || (dim_n[LOG2_T-1:0] != '0);

    logic k_last, j_last, i_last, r_last;
    assign k_last = (k_reg == k_tiles_reg - ONE_D);
    assign j_last = (j_reg == n_tiles_reg - ONE_D);
    assign i_last = (i_reg == m_tiles_reg - ONE_D);
    assign r_last = (r_reg == R_LAST);

    // Addresses derive from the index registers, which only move in ACCUM/WRITE,
    // so they hold steady from ISSUE until the product returns and while a beat stalls.
    logic [WIDE_W-1:0] base_a_wide, base_b_wide, wr_addr_wide;
    assign base_a_wide = widen_a(base_a_reg)
                       + ((widen_d(i_reg) * widen_d(dim_k_reg)) << LOG2_T)
                       + (widen_d(k_reg) << LOG2_T);
    assign base_b_wide = widen_a(base_b_reg)
                       + ((widen_d(k_reg) * widen_d(dim_n_reg)) << LOG2_T)
                       + (widen_d(j_reg) << LOG2_T);
    assign wr_addr_wide = widen_a(base_c_reg)
                        + (((widen_d(i_reg) << LOG2_T) + {{(WIDE_W-LOG2_T){1'b0}}, r_reg})
                           * widen_d(dim_n_reg))
                        + (widen_d(j_reg) << LOG2_T);

    assign mult_base_a   = base_a_wide[ADDR_W-1:0];
    assign mult_base_b   = base_b_wide[ADDR_W-1:0];
    assign wr_addr       = wr_addr_wide[ADDR_W-1:0];
    assign mult_stride_a = dim_k_reg;
    assign mult_stride_b = dim_n_reg;

    // mult_out is only guaranteed valid on the mult_done beat, so the partial
    // product is folded into the accumulator there; ACCUM then only steps indices.
    logic acc_en, acc_load;
    assign acc_en   = (state_reg == S_WAIT_MULT) && mult_done;
    assign acc_load = (k_reg == '0);

    logic [TILE*TILE*DATA_W-1:0] acc_flat;

    genvar gi, gj;
    generate
        for (gi = 0; gi < TILE; gi++) begin : g_row
            for (gj = 0; gj < TILE; gj++) begin : g_col
                logic [DATA_W-1:0] acc_reg;
                logic [DATA_W-1:0] prod;
                assign prod = mult_out[(gi*TILE+gj)*DATA_W +: DATA_W];
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n)
                        acc_reg <= '0;
                    else if (acc_en)
                        acc_reg <= acc_load ? prod : acc_add(acc_reg, prod);
                end
                assign acc_flat[(gi*TILE+gj)*DATA_W +: DATA_W] = acc_reg;
            end
        end
    endgenerate

    always_comb begin
        wr_data = '0;
        for (int ri = 0; ri < TILE; ri++) begin
            if (r_reg == LOG2_T'(ri))
                wr_data = acc_flat[ri*ROW_W +: ROW_W];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_dim     <= 1'b0;
            mult_start  <= 1'b0;
            wr_valid    <= 1'b0;
            m_tiles_reg <= '0;
            k_tiles_reg <= '0;
            n_tiles_reg <= '0;
            dim_k_reg   <= '0;
            dim_n_reg   <= '0;
            base_a_reg  <= '0;
            base_b_reg  <= '0;
            base_c_reg  <= '0;
            i_reg       <= '0;
            j_reg       <= '0;
            k_reg       <= '0;
            r_reg       <= '0;
        end else begin
            done       <= 1'b0;
            err_dim    <= 1'b0;
            mult_start <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        m_tiles_reg <= dim_m >> LOG2_T;
                        k_tiles_reg <= dim_k >> LOG2_T;
                        n_tiles_reg <= dim_n >> LOG2_T;
                        dim_k_reg   <= dim_k;
                        dim_n_reg   <= dim_n;
                        base_a_reg  <= base_a;
                        base_b_reg  <= base_b;
                        base_c_reg  <= base_c;
                        if (dims_bad) begin
                            err_dim <= 1'b1;
                        end else begin
                            busy       <= 1'b1;
                            i_reg      <= '0;
                            j_reg      <= '0;
                            k_reg      <= '0;
                            r_reg      <= '0;
                            mult_start <= 1'b1;
                            state_reg  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state_reg <= S_WAIT_MULT;
                S_WAIT_MULT: begin
                    if (mult_done)
                        state_reg <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (!k_last) begin
                        k_reg      <= k_reg + ONE_D;
                        mult_start <= 1'b1;
                        state_reg  <= S_ISSUE;
                    end else begin
                        r_reg     <= '0;
                        wr_valid  <= 1'b1;
                        state_reg <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        if (!r_last) begin
                            r_reg <= r_reg + ONE_R;
                        end else begin
                            wr_valid <= 1'b0;
                            k_reg    <= '0;
                            if (!j_last) begin
                                j_reg      <= j_reg + ONE_D;
                                mult_start <= 1'b1;
                                state_reg  <= S_ISSUE;
                            end else begin
                                j_reg <= '0;
                                if (i_last) begin
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    state_reg <= S_DONE;
                                end else begin
                                    i_reg      <= i_reg + ONE_D;
                                    mult_start <= 1'b1;
                                    state_reg  <= S_ISSUE;
                                end
                            end
                        end
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tiled_matmul_sequencer.sv
// Directed bench for tiled_matmul_sequencer: a behavioural tile multiplier and write sink
// respond on the falling edge; issue order, every C beat and the control pulses are checked.
module tb_tiled_matmul_sequencer;

    localparam int TILE   = 8;
    localparam int ADDR_W = 16;
    localparam int DIM_W  = 16;
    localparam int DATA_W = 32;
    localparam int MEM_N  = 2048;

    logic                        clock = 1'b0;
    logic                        reset_n;
    logic                        start;
    logic [DIM_W-1:0]            dim_m, dim_k, dim_n;
    logic [ADDR_W-1:0]           base_a, base_b, base_c;
    logic                        busy, done, err_dim, mult_start;
    logic [ADDR_W-1:0]           mult_base_a, mult_base_b;
    logic [DIM_W-1:0]            mult_stride_a, mult_stride_b;
    logic                        mult_done;
    logic [TILE*TILE*DATA_W-1:0] mult_out;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [ADDR_W-1:0]           wr_addr;
    logic [TILE*DATA_W-1:0]      wr_data;

    always #5 clock = ~clock;

    tiled_matmul_sequencer #(.TILE(TILE), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .busy(busy), .done(done), .err_dim(err_dim),
        .mult_start(mult_start), .mult_base_a(mult_base_a), .mult_base_b(mult_base_b),
        .mult_stride_a(mult_stride_a), .mult_stride_b(mult_stride_b),
        .mult_done(mult_done), .mult_out(mult_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    logic [31:0]  mem  [0:MEM_N-1];
    logic [31:0]  cref [0:31][0:31];
    logic [ADDR_W-1:0] exp_a[$], exp_b[$], exp_addr[$];
    logic [255:0] exp_data[$];
    int n_vec = 0, n_miss = 0;
    int iss_idx, beat_idx;
    int n_done = 0, n_err = 0, n_busy = 0, n_mstart = 0, n_wrv = 0;
    int mult_cnt = 0, stall_left = 0, stall_row = -1;
    int cur_k, cur_n;
    logic [255:0] last_data;
    logic [ADDR_W-1:0] cap_a, cap_b;
    logic [DIM_W-1:0]  cap_sa, cap_sb;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
`ifdef MATMUL_SATURATE_EN
        if (a[31] == b[31] && s[31] != a[31])
            s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return s;
    endfunction

    // Responders: tile multiplier with two-cycle latency, write sink with optional stall.
    always @(negedge clock) begin
        if (!reset_n) begin
            mult_cnt  = 0;
            mult_done = 1'b0;
            wr_ready  = 1'b1;
        end else begin
            if (done) begin
                n_done++;
                check("busy_at_done", {255'd0, busy}, 256'd0);
            end
            if (err_dim) n_err++;
            if (busy) n_busy++;
            mult_done = 1'b0;
            if (mult_cnt > 0) begin
                mult_cnt--;
                if (mult_cnt == 0) begin
                    for (int r = 0; r < TILE; r++)
                        for (int c = 0; c < TILE; c++) begin
                            logic [31:0] s;
                            s = 32'd0;
                            for (int t = 0; t < TILE; t++)
                                s += mem[(int'(cap_a) + r*int'(cap_sa) + t) % MEM_N] *
                                     mem[(int'(cap_b) + t*int'(cap_sb) + c) % MEM_N];
                            mult_out[(r*TILE+c)*DATA_W +: DATA_W] = s;
                        end
                    mult_done = 1'b1;
                end
            end
            if (mult_start) begin
                n_mstart++;
                if (iss_idx < exp_a.size()) begin
                    check("issue_a", 256'(mult_base_a), 256'(exp_a[iss_idx]));
                    check("issue_b", 256'(mult_base_b), 256'(exp_b[iss_idx]));
                    check("stride_a", 256'(mult_stride_a), 256'(cur_k));
                    check("stride_b", 256'(mult_stride_b), 256'(cur_n));
                end else begin
                    check("issue_extra", 256'd1, 256'd0);
                end
                iss_idx++;
                cap_a = mult_base_a; cap_b = mult_base_b;
                cap_sa = mult_stride_a; cap_sb = mult_stride_b;
                mult_cnt = 2;
            end
            if (wr_valid && stall_left > 0 && (beat_idx % TILE) == stall_row) begin
                wr_ready = 1'b0;
                stall_left--;
            end else begin
                wr_ready = 1'b1;
            end
            if (wr_valid) begin
                n_wrv++;
                if (beat_idx < exp_addr.size()) begin
                    check("wr_addr", 256'(wr_addr), 256'(exp_addr[beat_idx]));
                    check("wr_data", wr_data, exp_data[beat_idx]);
                end else begin
                    check("beat_extra", 256'd1, 256'd0);
                end
                if (wr_ready) begin
                    last_data = wr_data;
                    beat_idx++;
                end
            end
        end
    end

    task automatic build_expect(input int m, input int k, input int n,
                                input int ba, input int bb, input int bc);
        exp_a.delete(); exp_b.delete(); exp_addr.delete(); exp_data.delete();
        iss_idx = 0; beat_idx = 0; cur_k = k; cur_n = n;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++) begin
                logic [31:0] acc, part;
                acc = 32'd0;
                for (int kt = 0; kt < k/TILE; kt++) begin
                    part = 32'd0;
                    for (int t = 0; t < TILE; t++)
                        part += mem[(ba + r*k + kt*TILE + t) % MEM_N] *
                                mem[(bb + (kt*TILE + t)*n + c) % MEM_N];
                    acc = (kt == 0) ? part : ref_add(acc, part);
                end
                cref[r][c] = acc;
            end
        for (int i = 0; i < m/TILE; i++)
            for (int j = 0; j < n/TILE; j++) begin
                for (int kt = 0; kt < k/TILE; kt++) begin
                    exp_a.push_back(ADDR_W'(ba + i*TILE*k + kt*TILE));
                    exp_b.push_back(ADDR_W'(bb + kt*TILE*n + j*TILE));
                end
                for (int r = 0; r < TILE; r++) begin
                    logic [255:0] d;
                    for (int c = 0; c < TILE; c++)
                        d[c*32 +: 32] = cref[i*TILE+r][j*TILE+c];
                    exp_addr.push_back(ADDR_W'(bc + (i*TILE+r)*n + j*TILE));
                    exp_data.push_back(d);
                end
            end
    endtask

    task automatic start_op(input int m, input int k, input int n,
                            input int ba, input int bb, input int bc);
        build_expect(m, k, n, ba, bb, bc);
        dim_m = DIM_W'(m); dim_k = DIM_W'(k); dim_n = DIM_W'(n);
        base_a = ADDR_W'(ba); base_b = ADDR_W'(bb); base_c = ADDR_W'(bc);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", {255'd0, busy}, 256'd1);
    endtask

    task automatic wait_op(input bit poke);
        int d0, cyc;
        d0 = n_done;
        cyc = 0;
        while (n_done == d0 && cyc < 5000) begin
            // a start during an op must not disturb it
            start = (poke && cyc == 20) ? 1'b1 : 1'b0;
            if (poke && cyc == 20) dim_k = DIM_W'(8);
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        @(negedge clock);
        check("op_done", 256'(n_done - d0), 256'd1);
        check("beat_count", 256'(beat_idx), 256'(exp_addr.size()));
        check("mult_count", 256'(iss_idx), 256'(exp_a.size()));
    endtask

    task automatic fill_identity_ramp();
        for (int x = 0; x < MEM_N; x++) mem[x] = 32'd0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                mem[r*8+c]      = (r == c) ? 32'd1 : 32'd0;
                mem[64 + r*8+c] = 32'(r*8 + c);
            end
    endtask

    task automatic fill_ones();
        for (int x = 0; x < MEM_N; x++) mem[x] = 32'd0;
        for (int x = 0; x < 384; x++) mem[x] = 32'd1;
        for (int x = 512; x < 704; x++) mem[x] = 32'd1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {255'd0, busy}, 256'd0);
        check({tag, "_done"}, {255'd0, done}, 256'd0);
        check({tag, "_err"}, {255'd0, err_dim}, 256'd0);
        check({tag, "_mstart"}, {255'd0, mult_start}, 256'd0);
        check({tag, "_wrv"}, {255'd0, wr_valid}, 256'd0);
        check({tag, "_ba"}, 256'(mult_base_a), 256'd0);
        check({tag, "_bb"}, 256'(mult_base_b), 256'd0);
        check({tag, "_sa"}, 256'(mult_stride_a), 256'd0);
        check({tag, "_waddr"}, 256'(wr_addr), 256'd0);
        check({tag, "_wdata"}, wr_data, 256'd0);
    endtask

    initial begin
        int e0, b0, m0, v0, d0;
        reset_n = 1'b0; start = 1'b0;
        dim_m = '0; dim_k = '0; dim_n = '0;
        base_a = '0; base_b = '0; base_c = '0;
        mult_done = 1'b0; mult_out = '0; wr_ready = 1'b1;
        last_data = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // 8x8x8, A = I: C rows must equal B rows
        fill_identity_ramp();
        start_op(8, 8, 8, 0, 64, 128);
        wait_op(1'b0);
        check("ident_last_row", last_data, exp_data[7]);

        // same op with row 3 stalled for 5 cycles
        stall_row = 3; stall_left = 5;
        start_op(8, 8, 8, 0, 64, 128);
        wait_op(1'b0);
        check("stall_consumed", 256'(stall_left), 256'd0);
        stall_row = -1;

        // 16x16x16 walks i,j,k in order; a start mid-op is ignored
        for (int x = 0; x < MEM_N; x++) mem[x] = 32'd0;
        for (int x = 0; x < 256; x++) begin
            mem[x]       = 32'((x*7 + 3) % 97);
            mem[256 + x] = 32'((x*5 + 1) % 89);
        end
        start_op(16, 16, 16, 0, 256, 512);
        wait_op(1'b1);

        // three reduction steps per tile, all ones -> every element 24
        fill_ones();
        start_op(16, 24, 8, 0, 512, 1024);
        wait_op(1'b0);
        check("ones_elem0", 256'(last_data[31:0]), 256'd24);
        check("ones_elem7", 256'(last_data[255:224]), 256'd24);

        // bad dims: err_dim pulse only
        e0 = n_err; b0 = n_busy; m0 = n_mstart; v0 = n_wrv;
        dim_m = 16'd8; dim_k = 16'd12; dim_n = 16'd8;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("err_pulse", 256'(n_err - e0), 256'd1);
        check("err_busy", 256'(n_busy - b0), 256'd0);
        check("err_mstart", 256'(n_mstart - m0), 256'd0);
        check("err_wrvalid", 256'(n_wrv - v0), 256'd0);

        // reset while waiting on the multiplier aborts; a fresh start completes
        d0 = n_done;
        m0 = n_mstart;
        start_op(16, 24, 8, 0, 512, 1024);
        for (int c = 0; c < 20 && n_mstart == m0; c++) @(negedge clock);
        check("abort_saw_issue", 256'(n_mstart - m0), 256'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("abort_no_done", 256'(n_done - d0), 256'd0);
        start_op(16, 24, 8, 0, 512, 1024);
        wait_op(1'b0);
        check("fresh_elem", 256'(last_data[31:0]), 256'd24);

        // two steps of 0x7FFFFFF0: saturates or wraps depending on the build
        for (int x = 0; x < MEM_N; x++) mem[x] = 32'd0;
        for (int x = 0; x < 128; x++) begin
            mem[x]       = 32'h0FFF_FFFE;
            mem[512 + x] = 32'd1;
        end
        start_op(8, 16, 8, 0, 512, 1024);
        wait_op(1'b0);
`ifdef MATMUL_SATURATE_EN
        check("ovf_elem", 256'(last_data[31:0]), 256'h7FFF_FFFF);
`else
        check("ovf_elem", 256'(last_data[31:0]), 256'hFFFF_FFE0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
